// File: rtl/data_mem_lane_ctrl.sv
// Byte-lane data memory controller: turns one MEM-stage load/store into
// ceil(N/LANES) beats on a LANES-wide byte-addressed RAM, with optional
// address-setup cycles and sign/zero extension of load results.
module data_mem_lane_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int XLEN     = 32,
    parameter int LANES    = 2,
    parameter int WAIT_CYC = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [2:0]                req_width,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [XLEN-1:0]           req_wdata,
    output logic                      resp_valid,
    output logic                      resp_err,
    output logic [XLEN-1:0]           resp_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [LANES-1:0]          mem_be,
    output logic [LANES*ADDR_W-1:0]   mem_addr,
    output logic [LANES*8-1:0]        mem_wdata,
    input  logic [LANES*8-1:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, SETUP, BEAT, RESP} state_t;

    state_t                    state, state_nx;
    logic                      we_q;
    logic [2:0]                width_q;
    logic [6:0]                n_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [63:0]               wdata_q;
    logic [2:0]                b_q;
    logic [2:0]                wait_q;
    logic [63:0]               asm_q;

    logic [ADDR_W-1:0]         src_addr;
    logic [63:0]               src_wdata;
    logic [6:0]                src_n;
    logic [6:0]                src_b;
    logic [6:0]                idx;
    logic [6:0]                cidx;
    logic [LANES*ADDR_W-1:0]   lane_addr_nx;
    logic [LANES-1:0]          lane_be_nx;
    logic [LANES*8-1:0]        lane_wd_nx;
    logic [63:0]               asm_nx;
    logic [63:0]               load_ext;
    logic                      last_beat;

    // Bytes moved by a funct3 width code (B/H/W/D, unsigned variants alike)
    function automatic logic [6:0] byte_cnt(input logic [2:0] w);
        case (w[1:0])
            2'b00:   return 7'd1;
            2'b01:   return 7'd2;
            2'b10:   return 7'd4;
            default: return 7'd8;
        endcase
    endfunction

    // 111 never exists; D and WU only exist on a 64-bit datapath
    function automatic logic is_illegal(input logic [2:0] w);
        return (w == 3'b111) || ((XLEN == 32) && ((w == 3'b011) || (w == 3'b110)));
    endfunction

    // Sign-extend B/H/W from their top byte, zero-extend BU/HU/WU, D passes through
    function automatic logic [63:0] extend_load(input logic [63:0] raw, input logic [2:0] w);
        logic signed [7:0]  s8;
        logic signed [15:0] s16;
        logic signed [31:0] s32;
        logic signed [63:0] r;
        s8  = raw[7:0];
        s16 = raw[15:0];
        s32 = raw[31:0];
        case (w)
            3'b000:  r = s8;
            3'b001:  r = s16;
            3'b010:  r = s32;
            3'b100:  r = {56'd0, raw[7:0]};
            3'b101:  r = {48'd0, raw[15:0]};
            3'b110:  r = {32'd0, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    assign req_ready = (state == IDLE);

    // Lane outputs for the next beat: beat 0 from the request, later beats from latched state
    always_comb begin
        src_addr     = (state == IDLE) ? req_addr : addr_q;
        src_wdata    = (state == IDLE) ? 64'(req_wdata) : wdata_q;
        src_n        = (state == IDLE) ? byte_cnt(req_width) : n_q;
        src_b        = (state == IDLE) ? 7'd0 : (7'(b_q) + 7'd1);
        lane_addr_nx = '0;
        lane_be_nx   = '0;
        lane_wd_nx   = '0;
        idx          = '0;
        for (int i = 0; i < LANES; i++) begin
            idx = src_b * 7'(LANES) + 7'(i);
            lane_addr_nx[i*ADDR_W +: ADDR_W] = src_addr + ADDR_W'(idx);
            if (idx < src_n) begin
                lane_be_nx[i]          = 1'b1;
                lane_wd_nx[i*8 +: 8]   = src_wdata[{idx[2:0], 3'b000} +: 8];
            end
        end
    end

    // Merge the current beat's read bytes into the assembly buffer and detect the final beat
    always_comb begin
        asm_nx = asm_q;
        cidx   = '0;
        for (int i = 0; i < LANES; i++) begin
            cidx = 7'(b_q) * 7'(LANES) + 7'(i);
            if (mem_be[i]) begin
                asm_nx[{cidx[2:0], 3'b000} +: 8] = mem_rdata[i*8 +: 8];
            end
        end
        last_beat = ((7'(b_q) + 7'd1) * 7'(LANES)) >= n_q;
        load_ext  = extend_load(asm_nx, width_q);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (is_illegal(req_width)) state_nx = RESP;
                    else if (WAIT_CYC == 0)    state_nx = BEAT;
                    else                       state_nx = SETUP;
                end
            end
            SETUP:   if (wait_q == 3'd0) state_nx = BEAT;
            BEAT:    if (last_beat)      state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, beat sequencing, registered memory-side outputs and response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q       <= 1'b0;
            width_q    <= '0;
            n_q        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            b_q        <= '0;
            wait_q     <= '0;
            asm_q      <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        width_q <= req_width;
                        n_q     <= byte_cnt(req_width);
                        addr_q  <= req_addr;
                        wdata_q <= 64'(req_wdata);
                        b_q     <= '0;
                        asm_q   <= '0;
                        wait_q  <= 3'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);
                        if (is_illegal(req_width)) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            mem_addr  <= lane_addr_nx;
                            mem_be    <= lane_be_nx;
                            mem_wdata <= lane_wd_nx;
                            mem_en    <= (WAIT_CYC == 0);
                            mem_we    <= (WAIT_CYC == 0) && req_we;
                        end
                    end
                end
                SETUP: begin
                    if (wait_q == 3'd0) begin
                        mem_en <= 1'b1;
                        mem_we <= we_q;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                BEAT: begin
                    asm_q <= asm_nx;
                    if (last_beat) begin
                        mem_en     <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_be     <= '0;
                        mem_wdata  <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        if (!we_q) resp_rdata <= load_ext[XLEN-1:0];
                    end else begin
                        b_q       <= b_q + 3'd1;
                        mem_addr  <= lane_addr_nx;
                        mem_be    <= lane_be_nx;
                        mem_wdata <= lane_wd_nx;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_lane_ctrl.sv
// Bench for data_mem_lane_ctrl: a 2-lane/1-wait instance and a 4-lane/0-wait
// instance, each on its own byte memory, checked cycle by cycle against a
// request-level model of beats, lane addresses and extended load results.
module tb_data_mem_lane_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int sel    = 0;

    // Instance A: LANES=2, WAIT_CYC=1
    logic        a_req_valid = 0, a_req_we = 0;
    logic [2:0]  a_req_width = 0;
    logic [31:0] a_req_addr = 0, a_req_wdata = 0;
    logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_en, a_mem_we;
    logic [31:0] a_resp_rdata;
    logic [1:0]  a_mem_be;
    logic [63:0] a_mem_addr;
    logic [15:0] a_mem_wdata, a_mem_rdata;

    // Instance B: LANES=4, WAIT_CYC=0
    logic         b_req_valid = 0, b_req_we = 0;
    logic [2:0]   b_req_width = 0;
    logic [31:0]  b_req_addr = 0, b_req_wdata = 0;
    logic         b_req_ready, b_resp_valid, b_resp_err, b_mem_en, b_mem_we;
    logic [31:0]  b_resp_rdata;
    logic [3:0]   b_mem_be;
    logic [127:0] b_mem_addr;
    logic [31:0]  b_mem_wdata, b_mem_rdata;

    data_mem_lane_ctrl #(.ADDR_W(32), .XLEN(32), .LANES(2), .WAIT_CYC(1)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_width(a_req_width), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_err(a_resp_err), .resp_rdata(a_resp_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    data_mem_lane_ctrl #(.ADDR_W(32), .XLEN(32), .LANES(4), .WAIT_CYC(0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_width(b_req_width), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_err(b_resp_err), .resp_rdata(b_resp_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Byte memories, indexed by the low 12 address bits
    logic [7:0] mem_a [4096];
    logic [7:0] mem_b [4096];
    logic       init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int k = 0; k < 4096; k++) begin
                mem_a[k] <= 8'h00;
                mem_b[k] <= 8'h00;
            end
            mem_a[12'h101] <= 8'h34;
            mem_a[12'h102] <= 8'hF2;
            mem_a[12'h203] <= 8'h80;
            mem_b[12'hFFE] <= 8'h11;
            mem_b[12'hFFF] <= 8'h22;
            mem_b[12'h000] <= 8'h33;
            mem_b[12'h001] <= 8'h44;
            init_done <= 1'b1;
        end else begin
            if (a_mem_en && a_mem_we)
                for (int i = 0; i < 2; i++)
                    if (a_mem_be[i]) mem_a[a_mem_addr[i*32 +: 12]] <= a_mem_wdata[i*8 +: 8];
            if (b_mem_en && b_mem_we)
                for (int i = 0; i < 4; i++)
                    if (b_mem_be[i]) mem_b[b_mem_addr[i*32 +: 12]] <= b_mem_wdata[i*8 +: 8];
        end
    end

    always_comb begin
        a_mem_rdata = '0;
        b_mem_rdata = '0;
        for (int i = 0; i < 2; i++) a_mem_rdata[i*8 +: 8] = mem_a[a_mem_addr[i*32 +: 12]];
        for (int i = 0; i < 4; i++) b_mem_rdata[i*8 +: 8] = mem_b[b_mem_addr[i*32 +: 12]];
    end

    // Selected instance's outputs, padded to four lanes
    logic         v_en, v_we, v_rv, v_err, v_rdy;
    logic [3:0]   v_be;
    logic [127:0] v_addr;
    logic [31:0]  v_wd, v_rd;

    always_comb begin
        v_en = a_mem_en; v_we = a_mem_we; v_rv = a_resp_valid; v_err = a_resp_err;
        v_rdy = a_req_ready; v_be = {2'b00, a_mem_be}; v_addr = {64'd0, a_mem_addr};
        v_wd = {16'd0, a_mem_wdata}; v_rd = a_resp_rdata;
        if (sel != 0) begin
            v_en = b_mem_en; v_we = b_mem_we; v_rv = b_resp_valid; v_err = b_resp_err;
            v_rdy = b_req_ready; v_be = b_mem_be; v_addr = b_mem_addr;
            v_wd = b_mem_wdata; v_rd = b_resp_rdata;
        end
    end

    typedef struct packed {
        logic         en;
        logic         we;
        logic [3:0]   be;
        logic [127:0] addr;
        logic [31:0]  wd;
        logic         rv;
        logic         err;
        logic [31:0]  rd;
    } rec_t;

    rec_t        q[$];
    logic [31:0] last_rd [2] = '{32'd0, 32'd0};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return (sel == 0) ? mem_a[a[11:0]] : mem_b[a[11:0]];
    endfunction

    // Architectural load result: gather N bytes little-endian, then extend
    function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] w);
        int          n = 1 << w[1:0];
        logic [63:0] raw = '0;
        for (int j = 0; j < n; j++) raw = raw | (64'(rd_byte(a + 32'(j))) << (8 * j));
        if (!w[2] && raw[8*n-1]) raw = raw | ~((64'd1 << (8 * n)) - 64'd1);
        return raw[31:0];
    endfunction

    // Expected per-cycle outputs following an accepted request
    task automatic push_req(input logic we, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
        int   lanes = (sel == 0) ? 2 : 4;
        int   waits = (sel == 0) ? 1 : 0;
        int   n, nb, ix;
        rec_t r;
        if (w == 3'b111 || w == 3'b011 || w == 3'b110) begin
            r = '0; r.rv = 1'b1; r.err = 1'b1; r.rd = last_rd[sel];
            q.push_back(r);
            return;
        end
        n  = 1 << w[1:0];
        nb = (n + lanes - 1) / lanes;
        for (int k = 0; k < waits; k++) begin
            r = '0; r.rd = last_rd[sel];
            q.push_back(r);
        end
        for (int b = 0; b < nb; b++) begin
            r = '0; r.en = 1'b1; r.we = we; r.rd = last_rd[sel];
            for (int i = 0; i < lanes; i++) begin
                ix = b * lanes + i;
                r.addr[i*32 +: 32] = a + 32'(ix);
                if (ix < n) begin
                    r.be[i]         = 1'b1;
                    r.wd[i*8 +: 8]  = d[ix*8 +: 8];
                end
            end
            q.push_back(r);
        end
        if (!we) last_rd[sel] = load_val(a, w);
        r = '0; r.rv = 1'b1; r.rd = last_rd[sel];
        q.push_back(r);
    endtask

    // Compare process: every falling edge, DUT against the model
    initial begin
        rec_t r;
        logic rdy_exp;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                r = q.pop_front();
                rdy_exp = 1'b0;
            end else begin
                r = '0;
                r.rd = last_rd[sel];
                rdy_exp = 1'b1;
            end
            chk("req_ready", 128'(v_rdy), 128'(rdy_exp));
            chk("mem_en", 128'(v_en), 128'(r.en));
            chk("mem_we", 128'(v_we), 128'(r.we));
            chk("resp_valid", 128'(v_rv), 128'(r.rv));
            chk("resp_rdata", 128'(v_rd), 128'(r.rd));
            if (r.rv) chk("resp_err", 128'(v_err), 128'(r.err));
            if (r.en) begin
                chk("mem_be", 128'(v_be), 128'(r.be));
                chk("mem_addr", v_addr, r.addr);
                chk("mem_wdata", 128'(v_wd), 128'(r.wd));
            end
        end
    end

    task automatic drive(input logic v, input logic we, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            a_req_valid = v; a_req_we = we; a_req_width = w; a_req_addr = a; a_req_wdata = d;
        end else begin
            b_req_valid = v; b_req_we = we; b_req_width = w; b_req_addr = a; b_req_wdata = d;
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        #1 drive(1'b1, we, w, a, d);
        @(posedge clk);
        push_req(we, w, a, d);
        #1 drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        while (q.size() > 0 && n < 40) begin
            @(negedge clk);
            #2 n++;
        end
        if (q.size() > 0) chk("drain_timeout", 128'(q.size()), 128'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst a_req_ready", 128'(a_req_ready), 128'd1);
        chk("rst b_req_ready", 128'(b_req_ready), 128'd1);
        chk("rst a_mem_en", 128'(a_mem_en), 128'd0);
        chk("rst a_resp_valid", 128'(a_resp_valid), 128'd0);
        chk("rst a_mem_addr", 128'(a_mem_addr), 128'd0);
        rst = 1'b0;

        sel = 0;
        issue(1'b0, 3'b000, 32'h0000_0203, 32'hA5A5_A5A5);
        chk("LB rdata", 128'(a_resp_rdata), 128'h0000_0000_FFFF_FF80);
        issue(1'b0, 3'b100, 32'h0000_0203, 32'h0);
        chk("LBU rdata", 128'(a_resp_rdata), 128'h0000_0080);
        issue(1'b0, 3'b001, 32'h0000_0101, 32'h0);
        chk("LH odd rdata", 128'(a_resp_rdata), 128'h0000_0000_FFFF_F234);
        issue(1'b0, 3'b111, 32'h0000_0040, 32'h0);
        issue(1'b0, 3'b011, 32'h0000_0040, 32'h0);
        chk("illegal keeps rdata", 128'(a_resp_rdata), 128'h0000_0000_FFFF_F234);
        issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        chk("SW byte 100", 128'(mem_a[12'h100]), 128'hEF);
        chk("SW byte 101", 128'(mem_a[12'h101]), 128'hBE);
        chk("SW byte 102", 128'(mem_a[12'h102]), 128'hAD);
        chk("SW byte 103", 128'(mem_a[12'h103]), 128'hDE);

        // Asynchronous reset during the second beat of a store
        @(negedge clk);
        #1 drive(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h1122_3344);
        @(posedge clk);
        push_req(1'b1, 3'b010, 32'h0000_0100, 32'h1122_3344);
        #1 drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        q.delete();
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        #1;
        chk("abort mem_en", 128'(a_mem_en), 128'd0);
        chk("abort mem_we", 128'(a_mem_we), 128'd0);
        chk("abort mem_be", 128'(a_mem_be), 128'd0);
        chk("abort mem_addr", 128'(a_mem_addr), 128'd0);
        chk("abort mem_wdata", 128'(a_mem_wdata), 128'd0);
        chk("abort resp_rdata", 128'(a_resp_rdata), 128'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort req_ready", 128'(a_req_ready), 128'd1);
        chk("abort byte 100", 128'(mem_a[12'h100]), 128'h44);
        chk("abort byte 101", 128'(mem_a[12'h101]), 128'h33);
        chk("abort byte 102", 128'(mem_a[12'h102]), 128'hAD);
        chk("abort byte 103", 128'(mem_a[12'h103]), 128'hDE);

        // Four-lane instance, no setup cycles, address wrap
        sel = 1;
        issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
        chk("LW wrap rdata", 128'(b_resp_rdata), 128'h4433_2211);
        issue(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF);
        chk("SH wrap byte FFF", 128'(mem_b[12'hFFF]), 128'hEF);
        chk("SH wrap byte 000", 128'(mem_b[12'h000]), 128'hBE);
        chk("SH keeps rdata", 128'(b_resp_rdata), 128'h4433_2211);
        issue(1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0);
        chk("LHU wrap rdata", 128'(b_resp_rdata), 128'h0000_BEEF);

        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
